// File: rtl/lane_dispatcher_pkg.sv
// Shared constants and FSM state encoding for the lane dispatcher.
package lane_dispatcher_pkg;
  localparam int LANES       = 4;
  localparam int DATA_W      = 4;
  localparam int SEL_W       = 2;
  localparam int FIFO_DEPTH  = 2;
  localparam int STALL_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    DISPATCH,
    STALL
  } state_t;
endpackage

// File: rtl/dispatch_fifo2.sv
// Two-entry in-order word buffer; entry 0 is always the head.
module dispatch_fifo2
  import lane_dispatcher_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] e0_q, e0_d, e1_q, e1_d;

  // Caller never pushes when full or pops when empty.
  always_comb begin
    cnt_d = cnt_q;
    e0_d  = e0_q;
    e1_d  = e1_q;
    if (push && pop) begin
      if (cnt_q == 2'd1) begin
        e0_d = din;
      end else begin
        e0_d = e1_q;
        e1_d = din;
      end
    end else if (push) begin
      if (cnt_q == 2'd0) e0_d = din;
      else               e1_d = din;
      cnt_d = cnt_q + 2'd1;
    end else if (pop) begin
      e0_d  = e1_q;
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 2'd0;
    else     cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    e0_q <= e0_d;
    e1_q <= e1_d;
  end

  assign head  = e0_q;
  assign full  = (cnt_q == 2'(FIFO_DEPTH));
  assign empty = (cnt_q == 2'd0);
endmodule

// File: rtl/lane_dispatcher.sv
// Buffers words and dispatches each one to a round-robin-selected eligible lane.
module lane_dispatcher
  import lane_dispatcher_pkg::*;
#(
  parameter int STALL_MAX = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LANES-1:0]  lane_en,
  input  logic [LANES-1:0]  lane_ready,
  output logic [SEL_W-1:0]  select,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  output logic              stall_timeout
);
  localparam logic [STALL_CNT_W-1:0] STALL_MAX_C = STALL_CNT_W'(STALL_MAX);

  logic                   full, empty, push, grant, found;
  logic [DATA_W-1:0]      head;
  logic [LANES-1:0]       elig;
  logic [SEL_W-1:0]       idx, gnt;
  state_t                 state;
  logic [SEL_W-1:0]       ptr_q, ptr_d, select_q, select_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic                   valid_q, valid_d, timeout_q, timeout_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign elig     = lane_en & lane_ready;

  dispatch_fifo2 u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (grant),
    .din   (data_in),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  // The FIFO occupancy is the state register; the FSM state is decoded from it and lane eligibility.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int k = 0; k < LANES; k++) begin
      idx = ptr_q + SEL_W'(k);
      if (!found && elig[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end

    if (empty)      state = IDLE;
    else if (found) state = DISPATCH;
    else            state = STALL;

    grant       = (state == DISPATCH);
    ptr_d       = grant ? gnt + SEL_W'(1) : ptr_q;
    select_d    = grant ? gnt : select_q;
    data_d      = grant ? head : '0;
    valid_d     = grant;

    stall_cnt_d = stall_cnt_q;
    if (grant)
      stall_cnt_d = '0;
    else if (state == STALL && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 1'b1;
    timeout_d   = timeout_q || (stall_cnt_d == STALL_MAX_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      select_q    <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      select_q    <= select_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign select        = select_q;
  assign data_out      = data_q;
  assign out_valid     = valid_q;
  assign stall_timeout = timeout_q;
endmodule

// File: doc/lane_dispatcher.md
LANE_DISPATCHER -- requirements
Module: lane_dispatcher

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 data_in  input  4  incoming word.
REQ-005 in_valid  input  1  data_in is valid this cycle.
REQ-006 in_ready  output  1  block can accept a word this cycle.
REQ-007 lane_en  input  4  per-lane enable; bit i enables lane i.
REQ-008 lane_ready  input  4  per-lane sink-ready; bit i means lane i can take a word.
REQ-009 select  output  2  destination lane index, which drives the downstream 1:4 demux select.
REQ-010 data_out  output  4  word to dispatch, which drives the downstream demux data input.
REQ-011 out_valid  output  1  one-cycle pulse marking a dispatched word.
REQ-012 stall_timeout  output  1  sticky flag for a prolonged stall.
REQ-013 Parameter STALL_MAX, default 255: number of stall cycles after which stall_timeout SHALL set.

Function
REQ-014 The block SHALL buffer input words in a 2-entry FIFO.
- in_ready = !full, taken from registered state only (no combinational path from in_valid or lane_ready).
- Push occurs when in_valid && in_ready at a rising edge.
REQ-015 The state machine SHALL have three states:
- IDLE: FIFO empty.
- DISPATCH: FIFO non-empty and at least one eligible lane.
- STALL: FIFO non-empty and no eligible lane.
- A lane is eligible when lane_en[i] && lane_ready[i].
REQ-016 In DISPATCH, the grant SHALL go round-robin:
- Search starts at lane ptr and proceeds ptr, ptr+1, ... modulo 4.
- The first eligible lane wins.
- On grant: ptr <= granted lane + 1 (3 wraps to 0).
REQ-017 On a grant edge the block SHALL pop the FIFO head and register three outputs:
- data_out <= head word.
- select <= granted lane.
- out_valid <= 1 for exactly one cycle.
REQ-018 Latency and throughput SHALL be as follows:
- A word pushed at edge k into an empty FIFO with an eligible lane appears with out_valid=1 after edge k+1.
- Sustained throughput is one word per cycle.
REQ-019 When out_valid=0, data_out SHALL be 0 and select SHALL hold its last value, so all demux lanes read zero.
REQ-020 Simultaneous push and pop SHALL keep the FIFO occupancy unchanged and preserve word order.
REQ-021 When lane_en = 4'b0000, the block SHALL enter or stay in STALL whenever the FIFO is non-empty; words SHALL never be dropped.
REQ-022 Stall counting SHALL work as follows:
- An 8-bit saturating stall_cnt increments on each cycle spent in STALL.
- stall_cnt clears on any grant.
- stall_timeout sets when stall_cnt reaches STALL_MAX and stays set until reset.
REQ-023 The FIFO SHALL keep word order; a word SHALL never be dispatched twice.

Reset
REQ-024 While rst=1 at a rising edge, the block SHALL be returned to its initial state:
- FIFO emptied; ptr=0; state=IDLE; stall_cnt=0.
- select=0, data_out=0, out_valid=0, stall_timeout=0.
- in_ready=1 from the first cycle after rst deasserts.
REQ-025 Reset in mid-operation SHALL discard buffered words, and no out_valid pulse SHALL occur on the reset edge.

Structure
REQ-026 A shared package SHALL hold the constants and the state encoding:
- LANES=4, DATA_W=4, SEL_W=2, FIFO_DEPTH=2, STALL_CNT_W=8.
- State enum: IDLE, DISPATCH, STALL.
REQ-027 The 2-entry FIFO SHALL be a sub-module named dispatch_fifo2 with push/pop/full/empty and a head-word output; the arbiter and FSM SHALL stay in lane_dispatcher.

Verification
REQ-028 Reset check: rst=1 for 2 cycles with in_valid=1 and data_in=4'hA -> select=0, data_out=0, out_valid=0, in_ready=1 after release; no word is dispatched.
REQ-029 Round-robin: lane_en=4'hF, lane_ready=4'hF, push 4'h1,4'h2,4'h3,4'h4,4'h5 on consecutive cycles -> pulses with select 0,1,2,3,0 and data 1,2,3,4,5, one per cycle.
REQ-030 Lane skip: lane_en=4'b1010, lane_ready=4'hF, push 4'h6,4'h7,4'h8 -> select 1,3,1 and data 6,7,8.
REQ-031 Backpressure: lane_ready=0, push 4'h9,4'hB,4'hC -> only the first two are accepted, in_ready=0 from the edge after the second push; then lane_ready=4'h4 -> select 2 with data 9, then select 2 with data B.
REQ-032 Timeout: lane_en=0 with one word buffered, STALL_MAX=255 -> stall_timeout=1 after the 255th stall cycle and remains 1 after lane_en=4'hF allows the word out.
REQ-033 Mid-operation reset: FIFO full, rst pulsed for one cycle -> no out_valid pulse; a new push of 4'hE then dispatches on select 0.
